// File: rtl/mult_sequencer.sv
// Sequencer that loads signed 16-bit operand pairs from byte memory, multiplies them, and writes 32-bit products back big-endian.
// Define MULT_SEQ_FASTMUL_EN to replace the 16-cycle radix-2 Booth datapath with a single-cycle multiply. The results are the same in both builds.
module mult_sequencer #(
  parameter int NPAIRS    = 16,
  parameter int OP_BASE   = 0,
  parameter int PROD_BASE = 64,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic [7:0]    mem_wdata,
  output logic          mem_we
);

  localparam int KW = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_STORE,
    S_FIN
  } state_e;

  state_e        state_q, state_d;
  logic          armed_q, armed_d;
  logic [KW-1:0] k_q, k_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   a_q, a_d;
  logic [15:0]   b_q, b_d;
  logic [16:0]   hi_q, hi_d;
  logic [15:0]   lo_q, lo_d;
  logic          qm1_q, qm1_d;

  logic [31:0]   prod_w;
  logic [16:0]   bx_w;
  logic [16:0]   sum_w;

  assign prod_w = {hi_q[15:0], lo_q};
  assign bx_w   = {b_q[15], b_q};

`ifdef MULT_SEQ_FASTMUL_EN
  logic signed [31:0] fast_prod_w;
  assign fast_prod_w = $signed(a_q) * $signed(b_q);
`endif

  // NOTE: The state register uses non-blocking assignments. Combinational logic uses blocking
  // assignments. Datapath registers are reset as well so that outputs are defined after a mid-run reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
      k_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qm1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qm1_q   <= qm1_d;
    end
  end

  // NOTE: Every signal gets a default value first, so no path through the case statement can infer a latch.
  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q | start;
    k_d       = k_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    qm1_d     = qm1_q;
    sum_w     = hi_q;
    done      = 1'b0;
    busy      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      S_IDLE: begin
        if (!start && armed_q) begin
          state_d = S_LOAD;
          armed_d = 1'b0;
          k_d     = '0;
          cnt_d   = '0;
        end
      end

      S_LOAD: begin
        busy     = 1'b1;
        mem_addr = AW'(OP_BASE + 4 * int'(k_q) + int'(cnt_q[1:0]));
        if (start) begin
          state_d = S_IDLE;
        end else begin
          case (cnt_q[1:0])
            2'd0: a_d[15:8] = mem_rdata;
            2'd1: a_d[7:0]  = mem_rdata;
            2'd2: b_d[15:8] = mem_rdata;
            2'd3: b_d[7:0]  = mem_rdata;
          endcase
          if (cnt_q[1:0] == 2'd3) begin
            // A is complete by now, so seed the Booth accumulator with it as the multiplier.
            state_d = S_MUL;
            cnt_d   = '0;
            hi_d    = '0;
            lo_d    = a_q;
            qm1_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      S_MUL: begin
        busy = 1'b1;
        if (start) begin
          state_d = S_IDLE;
        end else begin
`ifdef MULT_SEQ_FASTMUL_EN
          hi_d    = {fast_prod_w[31], fast_prod_w[31:16]};
          lo_d    = fast_prod_w[15:0];
          state_d = S_STORE;
          cnt_d   = '0;
`else
          case ({lo_q[0], qm1_q})
            2'b01:   sum_w = hi_q + bx_w;
            2'b10:   sum_w = hi_q - bx_w;
            default: sum_w = hi_q;
          endcase
          hi_d  = {sum_w[16], sum_w[16:1]};
          lo_d  = {sum_w[0], lo_q[15:1]};
          qm1_d = lo_q[0];
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = S_STORE;
            cnt_d   = '0;
          end
`endif
        end
      end

      S_STORE: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        mem_addr = AW'(PROD_BASE + 4 * int'(k_q) + int'(cnt_q[1:0]));
        case (cnt_q[1:0])
          2'd0: mem_wdata = prod_w[31:24];
          2'd1: mem_wdata = prod_w[23:16];
          2'd2: mem_wdata = prod_w[15:8];
          2'd3: mem_wdata = prod_w[7:0];
        endcase
        if (start) begin
          state_d = S_IDLE;
        end else if (cnt_q[1:0] == 2'd3) begin
          cnt_d = '0;
          if (k_q == KW'(NPAIRS - 1)) begin
            state_d = S_FIN;
          end else begin
            state_d = S_LOAD;
            armed_d = 1'b0;
            k_d     = k_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_FIN: begin
        done = 1'b1;
        if (start) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer. It checks a 1-pair instance and a 16-pair instance, each against its own byte-memory model.
module tb_mult_sequencer;

`ifdef MULT_SEQ_FASTMUL_EN
  localparam int PER_PAIR = 9;
`else
  localparam int PER_PAIR = 24;
`endif
  localparam int ONE_EDGES  = PER_PAIR + 1;
  localparam int FULL_EDGES = 16 * PER_PAIR + 1;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs [16];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_f = 1'b1, start_1 = 1'b1;
  logic       done_f, busy_f, we_f, done_1, busy_1, we_1;
  logic [7:0] addr_f, wdata_f, rdata_f, addr_1, wdata_1, rdata_1;

  logic [7:0] mem_f [256];
  logic [7:0] mem_1 [256];
  logic [7:0] init_f [256];
  logic [7:0] init_1 [256];
  logic       do_init_f = 1'b0, do_init_1 = 1'b0;
  int         we_cnt_f = 0, bad_wr_f = 0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mult_sequencer u_full (
    .clk(clk), .rst_n(rst_n), .start(start_f), .done(done_f), .busy(busy_f),
    .mem_addr(addr_f), .mem_rdata(rdata_f), .mem_wdata(wdata_f), .mem_we(we_f)
  );

  mult_sequencer #(.NPAIRS(1)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start_1), .done(done_1), .busy(busy_1),
    .mem_addr(addr_1), .mem_rdata(rdata_1), .mem_wdata(wdata_1), .mem_we(we_1)
  );

  assign rdata_f = mem_f[addr_f];
  assign rdata_1 = mem_1[addr_1];

  always @(posedge clk) begin
    if (do_init_f) begin
      for (int i = 0; i < 256; i++) mem_f[i] <= init_f[i];
    end else if (we_f) begin
      mem_f[addr_f] <= wdata_f;
    end
    if (we_f) begin
      we_cnt_f <= we_cnt_f + 1;
      if (addr_f < 8'd64 || addr_f > 8'd127) bad_wr_f <= bad_wr_f + 1;
    end
  end

  always @(posedge clk) begin
    if (do_init_1) begin
      for (int i = 0; i < 256; i++) mem_1[i] <= init_1[i];
    end else if (we_1) begin
      mem_1[addr_1] <= wdata_1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_full();
    for (int i = 0; i < 256; i++) init_f[i] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      init_f[4*i]      = vecs[i].a[15:8];
      init_f[4*i+1]    = vecs[i].a[7:0];
      init_f[4*i+2]    = vecs[i].b[15:8];
      init_f[4*i+3]    = vecs[i].b[7:0];
      init_f[64+4*i]   = 8'hAA;
      init_f[64+4*i+1] = 8'hAA;
      init_f[64+4*i+2] = 8'hAA;
      init_f[64+4*i+3] = 8'hAA;
    end
    do_init_f = 1'b1;
    tick();
    do_init_f = 1'b0;
  endtask

  function automatic logic [31:0] prod_at(input int k);
    return {mem_f[64+4*k], mem_f[64+4*k+1], mem_f[64+4*k+2], mem_f[64+4*k+3]};
  endfunction

  // Drops start (armed beforehand). Counts edges, with the launching edge as edge 1, until done is seen.
  task automatic run_full(input string name);
    int n;
    int we0;
    we0 = we_cnt_f;
    start_f = 1'b0;
    n = 0;
    while (n < 2000) begin
      @(posedge clk);
      n++;
      #1;
      if (done_f) break;
    end
    check({name, "_edges"}, n, FULL_EDGES);
    check({name, "_we_count"}, we_cnt_f - we0, 64);
  endtask

  task automatic check_products(input string name);
    int bad;
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_prod%0d", name, i), prod_at(i), vecs[i].p);
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem_f[i] !== init_f[i]) bad++;
    check({name, "_operands_intact"}, bad, 0);
    check({name, "_stray_writes"}, bad_wr_f, 0);
  endtask

  initial begin
    int n;
    int cnt;
    int we0;

    vecs[0]  = '{16'h0003, 16'hFFFE, 32'hFFFF_FFFA};
    vecs[1]  = '{16'h8000, 16'h8000, 32'h4000_0000};
    vecs[2]  = '{16'h8000, 16'h7FFF, 32'hC000_8000};
    vecs[3]  = '{16'h0000, 16'h1234, 32'h0000_0000};
    vecs[4]  = '{16'h7FFF, 16'h7FFF, 32'h3FFF_0001};
    vecs[5]  = '{16'hFFFF, 16'hFFFF, 32'h0000_0001};
    vecs[6]  = '{16'hFFFF, 16'h8000, 32'h0000_8000};
    vecs[7]  = '{16'h0100, 16'h0100, 32'h0001_0000};
    vecs[8]  = '{16'h1234, 16'h0001, 32'h0000_1234};
    vecs[9]  = '{16'h0001, 16'hFFFF, 32'hFFFF_FFFF};
    vecs[10] = '{16'h0010, 16'hF000, 32'hFFFF_0000};
    vecs[11] = '{16'h00FF, 16'h00FF, 32'h0000_FE01};
    vecs[12] = '{16'h1000, 16'h1000, 32'h0100_0000};
    vecs[13] = '{16'h7FFF, 16'h8001, 32'hC000_FFFF};
    vecs[14] = '{16'h0010, 16'h1234, 32'h0001_2340};
    vecs[15] = '{16'hFF00, 16'h0100, 32'hFFFF_0000};

    // Reset state
    #3;
    check("rst_done",  done_f, 0);
    check("rst_busy",  busy_f, 0);
    check("rst_we",    we_f, 0);
    check("rst_addr",  addr_f, 0);
    check("rst_wdata", wdata_f, 0);
    check("rst_done1", done_1, 0);
    #10 rst_n = 1'b1;
    tick();

    // Single pair on the NPAIRS=1 instance
    for (int i = 0; i < 256; i++) init_1[i] = 8'h00;
    init_1[0] = 8'h00; init_1[1] = 8'h03; init_1[2] = 8'hFF; init_1[3] = 8'hFE;
    do_init_1 = 1'b1;
    tick();
    do_init_1 = 1'b0;
    start_1 = 1'b0;
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (done_1) break;
    end
    check("one_edges", n, ONE_EDGES);
    check("one_prod", {mem_1[64], mem_1[65], mem_1[66], mem_1[67]}, 32'hFFFF_FFFA);
    check("one_busy_fin", busy_1, 0);

    // Full 16-pair run
    load_full();
    tick();
    run_full("run1");
    check("run1_busy_fin", busy_f, 0);
    check_products("run1");

    // Holding start low after done must not relaunch
    we0 = we_cnt_f;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!done_f) cnt++;
    end
    check("hold_we_count", we_cnt_f - we0, 0);
    check("hold_done_drops", cnt, 0);
    start_f = 1'b1;
    tick();
    check("fin_exit_done", done_f, 0);

    // Abort 100 edges into a run
    load_full();
    start_f = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check("abort_busy_before", busy_f, 1);
    start_f = 1'b1;
    tick();
    check("abort_busy", busy_f, 0);
    check("abort_we", we_f, 0);
    check("abort_prod2_kept", prod_at(2), vecs[2].p);
    check("abort_prod3_kept", prod_at(3), vecs[3].p);
    check("abort_prod4_untouched", prod_at(4), 32'hAAAA_AAAA);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (done_f || busy_f) cnt++;
    end
    check("abort_stays_idle", cnt, 0);

    // A fresh launch after the abort completes correctly
    load_full();
    run_full("run2");
    check_products("run2");

    // Asynchronous reset in the middle of MUL
    start_f = 1'b1;
    tick();
    start_f = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy_before", busy_f, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  busy_f, 0);
    check("mid_rst_done",  done_f, 0);
    check("mid_rst_we",    we_f, 0);
    check("mid_rst_addr",  addr_f, 0);
    check("mid_rst_wdata", wdata_f, 0);
    #2 rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (busy_f) cnt++;
    end
    check("post_rst_no_launch", cnt, 0);
    start_f = 1'b1;
    tick();
    start_f = 1'b0;
    tick();
    check("post_rst_relaunch", busy_f, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
